// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the host-link UART.
// Used by the transmit stage and its baud counter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_sr_baud_tick_counter.sv
// baud_tick_counter: free-running bit-period divider.
// Emits a one-cycle tick on the terminal count and wraps to zero.
module baud_tick_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == TERM);

    // Count cycles within the current bit; restart on every byte capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == TERM) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sr.sv
// uart_tx_sr: 8N1 serial transmitter fed by the byte-source stage.
// Captures a byte, pulses inc_data, shifts it out LSB first.
module uart_tx_sr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       data_valid,
    input  logic [7:0] tx_data,
    output logic       inc_data,
    output logic       tx_out,
    output logic       busy
);

    tx_state_t                 state;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [2:0]                bit_idx;
    logic                      tick;
    logic                      capture;

    // A new byte is taken only from IDLE or at the final STOP cycle,
    // which keeps the frame immutable and allows gapless back-to-back.
    assign capture = data_valid &&
                     ((state == IDLE) || ((state == STOP) && tick));

    assign busy = (state != IDLE);

    baud_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (capture),
        .enable (busy),
        .tick   (tick)
    );

    // Frame sequencer; tx_out is loaded with the level of the state
    // being entered so the line is registered yet has no extra latency.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_out    <= 1'b1;
            inc_data  <= 1'b0;
        end else begin
            inc_data <= capture;
            if (capture) begin
                state     <= START;
                shift_reg <= tx_data;
                bit_idx   <= '0;
                tx_out    <= 1'b0;
            end else if (tick) begin
                unique case (state)
                    START: begin
                        state  <= DATA;
                        tx_out <= shift_reg[0];
                    end
                    DATA: begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= '0;
                            tx_out  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_out  <= shift_reg[1];
                        end
                    end
                    STOP: begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sr.sv
// tb_uart_tx_sr: directed self-checking bench for uart_tx_sr.
// CLKS_PER_BIT = 4, so one frame spans 40 clocks.
module tb_uart_tx_sr;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       inc_data;
    logic       tx_out;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic       obs_tx   [0:127];
    logic       obs_busy [0:127];
    logic       obs_inc  [0:127];
    logic [7:0] src_q [$];
    bit         src_mode = 1'b0;

    uart_tx_sr #(
        .CLKS_PER_BIT(4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .data_valid (data_valid),
        .tx_data    (tx_data),
        .inc_data   (inc_data),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected line level at cycle i of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int s;
        s = i / 4;
        if (s == 0) return 1'b0;
        if (s >= 9) return 1'b1;
        return b[s-1];
    endfunction

    // Record outputs at negedges; in source mode, act as the byte source
    // and advance on every inc_data pulse.
    task automatic sample(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            obs_tx[i]   = tx_out;
            obs_busy[i] = busy;
            obs_inc[i]  = inc_data;
            if (src_mode && inc_data) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                if (src_q.size() == 0) data_valid = 1'b0;
                else tx_data = src_q[0];
            end
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (tx_out !== 1'b1) begin
            fails++;
            $display("FAIL reset tx_out: got %b want 1", tx_out);
        end
        tests++;
        if (inc_data !== 1'b0) begin
            fails++;
            $display("FAIL reset inc_data: got %b want 0", inc_data);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
        n_rst = 1'b1;
        sample(0, 50);
        for (int i = 0; i < 50; i++) begin
            tests++;
            if (obs_tx[i] !== 1'b1 || obs_busy[i] !== 1'b0 ||
                obs_inc[i] !== 1'b0) begin
                fails++;
                $display("FAIL idle[%0d]: tx/busy/inc %b%b%b want 100",
                         i, obs_tx[i], obs_busy[i], obs_inc[i]);
            end
        end
    endtask

    task automatic test_single_byte;
        @(negedge clk);
        src_mode = 1'b1;
        src_q = '{8'hA5};
        tx_data = 8'hA5;
        data_valid = 1'b1;
        sample(0, 44);
        for (int i = 0; i < 44; i++) begin
            logic et, eb, ei;
            et = (i < 40) ? exp_bit(8'hA5, i) : 1'b1;
            eb = (i < 40);
            ei = (i == 0);
            tests++;
            if (obs_tx[i] !== et) begin
                fails++;
                $display("FAIL single tx[%0d]: got %b want %b", i, obs_tx[i], et);
            end
            tests++;
            if (obs_busy[i] !== eb) begin
                fails++;
                $display("FAIL single busy[%0d]: got %b want %b", i, obs_busy[i], eb);
            end
            tests++;
            if (obs_inc[i] !== ei) begin
                fails++;
                $display("FAIL single inc[%0d]: got %b want %b", i, obs_inc[i], ei);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        src_mode = 1'b1;
        src_q = '{8'h00, 8'hFF};
        tx_data = 8'h00;
        data_valid = 1'b1;
        sample(0, 84);
        for (int i = 0; i < 84; i++) begin
            logic et, eb, ei;
            if (i < 40) et = exp_bit(8'h00, i);
            else if (i < 80) et = exp_bit(8'hFF, i - 40);
            else et = 1'b1;
            eb = (i < 80);
            ei = (i == 0) || (i == 40);
            tests++;
            if (obs_tx[i] !== et) begin
                fails++;
                $display("FAIL b2b tx[%0d]: got %b want %b", i, obs_tx[i], et);
            end
            tests++;
            if (obs_busy[i] !== eb) begin
                fails++;
                $display("FAIL b2b busy[%0d]: got %b want %b", i, obs_busy[i], eb);
            end
            tests++;
            if (obs_inc[i] !== ei) begin
                fails++;
                $display("FAIL b2b inc[%0d]: got %b want %b", i, obs_inc[i], ei);
            end
        end
    endtask

    task automatic test_mid_frame;
        @(negedge clk);
        src_mode = 1'b0;
        tx_data = 8'h5A;
        data_valid = 1'b1;
        sample(0, 14);
        data_valid = 1'b0;
        tx_data = 8'h3C;
        sample(14, 48);
        for (int i = 0; i < 48; i++) begin
            logic et, eb, ei;
            et = (i < 40) ? exp_bit(8'h5A, i) : 1'b1;
            eb = (i < 40);
            ei = (i == 0);
            tests++;
            if (obs_tx[i] !== et || obs_busy[i] !== eb ||
                obs_inc[i] !== ei) begin
                fails++;
                $display("FAIL midframe[%0d]: tx/busy/inc %b%b%b want %b%b%b",
                         i, obs_tx[i], obs_busy[i], obs_inc[i], et, eb, ei);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        src_mode = 1'b1;
        src_q = '{8'h00};
        tx_data = 8'h00;
        data_valid = 1'b1;
        sample(0, 16);
        tests++;
        if (obs_tx[15] !== 1'b0 || obs_busy[15] !== 1'b1) begin
            fails++;
            $display("FAIL rstmid pre: tx/busy %b%b want 01",
                     obs_tx[15], obs_busy[15]);
        end
        #2 n_rst = 1'b0;
        #1;
        tests++;
        if (tx_out !== 1'b1) begin
            fails++;
            $display("FAIL rstmid tx_out: got %b want 1", tx_out);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid busy: got %b want 0", busy);
        end
        tests++;
        if (inc_data !== 1'b0) begin
            fails++;
            $display("FAIL rstmid inc: got %b want 0", inc_data);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        sample(0, 30);
        for (int i = 0; i < 30; i++) begin
            tests++;
            if (obs_tx[i] !== 1'b1 || obs_busy[i] !== 1'b0 ||
                obs_inc[i] !== 1'b0) begin
                fails++;
                $display("FAIL rstmid idle[%0d]: tx/busy/inc %b%b%b want 100",
                         i, obs_tx[i], obs_busy[i], obs_inc[i]);
            end
        end
    endtask

    task automatic test_boundary;
        @(negedge clk);
        src_mode = 1'b1;
        src_q = '{8'hC3};
        tx_data = 8'hC3;
        data_valid = 1'b1;
        sample(0, 40);
        src_q = '{8'h96};
        tx_data = 8'h96;
        data_valid = 1'b1;
        sample(40, 84);
        for (int i = 0; i < 84; i++) begin
            logic et, eb, ei;
            if (i < 40) et = exp_bit(8'hC3, i);
            else if (i < 80) et = exp_bit(8'h96, i - 40);
            else et = 1'b1;
            eb = (i < 80);
            ei = (i == 0) || (i == 40);
            tests++;
            if (obs_tx[i] !== et || obs_busy[i] !== eb ||
                obs_inc[i] !== ei) begin
                fails++;
                $display("FAIL boundary[%0d]: tx/busy/inc %b%b%b want %b%b%b",
                         i, obs_tx[i], obs_busy[i], obs_inc[i], et, eb, ei);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_mid_frame();
        test_reset_mid_frame();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
